// File: rtl/ppu_line_buf_pkg.sv
// ppu_line_buf_pkg: shared geometry constants and control states for the PPU scanline buffer.
package ppu_line_buf_pkg;
    localparam int NES_W = 256;
    localparam int NES_H = 240;
    localparam int IDX_W = 6;
    localparam int X_W   = $clog2(NES_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } state_e;
endpackage

// File: rtl/ppu_line_buf_bank.sv
// ppu_line_buf_bank: one NES_W x IDX_W line bank, synchronous write and asynchronous read.
module ppu_line_buf_bank
    import ppu_line_buf_pkg::*;
(
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [X_W-1:0]   waddr_i,
    input  logic [IDX_W-1:0] wdata_i,
    input  logic [X_W-1:0]   raddr_i,
    output logic [IDX_W-1:0] rdata_o
);
    logic [IDX_W-1:0] mem_q [NES_W];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ppu_line_buf.sv
// ppu_line_buf: ping-pong scanline buffer between the PPU renderer and the VGA output.
// Define PPU_LINE_BUF_UNDERRUN_CNT_EN to build the saturating underrun counter.
module ppu_line_buf
    import ppu_line_buf_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [9:0]       nes_x_in,
    input  logic [9:0]       nes_y_in,
    input  logic [9:0]       nes_y_next_in,
    input  logic             pix_pulse_in,
    output logic [IDX_W-1:0] sys_palette_idx_out,
    output logic             line_req_out,
    output logic [7:0]       line_num_out,
    input  logic             wr_en_in,
    input  logic [X_W-1:0]   wr_x_in,
    input  logic [IDX_W-1:0] wr_idx_in,
    input  logic             wr_done_in,
    output logic             underrun_out,
    output logic [15:0]      underrun_cnt_out
);
    state_e           state_q, state_d;
    logic             rd_bank_q, rd_bank_d;
    logic [7:0]       line_num_q, line_num_d;
    logic             req_q, req_d;
    logic             und_q, und_d;
    logic             wr_ok, eol, y_vis, y_match;
    logic [7:0]       tgt;
    logic [IDX_W-1:0] rd0, rd1;

    // The renderer always writes the bank that is not being displayed.
    assign wr_ok = wr_en_in && state_q == FILL;

    ppu_line_buf_bank u_bank0 (
        .clk_i   (clk_in),
        .we_i    (wr_ok && rd_bank_q),
        .waddr_i (wr_x_in),
        .wdata_i (wr_idx_in),
        .raddr_i (nes_x_in[X_W-1:0]),
        .rdata_o (rd0)
    );

    ppu_line_buf_bank u_bank1 (
        .clk_i   (clk_in),
        .we_i    (wr_ok && !rd_bank_q),
        .waddr_i (wr_x_in),
        .wdata_i (wr_idx_in),
        .raddr_i (nes_x_in[X_W-1:0]),
        .rdata_o (rd1)
    );

    assign sys_palette_idx_out = (nes_x_in >= 10'(NES_W) || nes_y_in >= 10'(NES_H)) ? '0
                               : (rd_bank_q ? rd1 : rd0);

    assign eol     = pix_pulse_in && nes_x_in == 10'(NES_W - 1) && nes_y_next_in != nes_y_in;
    assign y_vis   = nes_y_next_in < 10'(NES_H);
    assign y_match = nes_y_next_in == {2'b00, line_num_q};
    assign tgt     = (nes_y_next_in == 10'(NES_H - 1)) ? 8'd0 : 8'(nes_y_next_in + 10'd1);

    always_comb begin
        state_d    = (state_q == FILL && wr_done_in) ? READY : state_q;
        rd_bank_d  = rd_bank_q;
        line_num_d = line_num_q;
        req_d      = 1'b0;
        und_d      = 1'b0;
        if (eol && y_vis && (state_q == IDLE || y_match)) begin
            req_d      = 1'b1;
            line_num_d = tgt;
            state_d    = FILL;
            // A done pulse coinciding with the eol still counts as a finished line.
            if (state_q != IDLE) begin
                rd_bank_d = (state_q == READY || wr_done_in) ? !rd_bank_q : rd_bank_q;
                und_d     = !(state_q == READY || wr_done_in);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            rd_bank_q  <= 1'b0;
            line_num_q <= '0;
            req_q      <= 1'b0;
            und_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_bank_q  <= rd_bank_d;
            line_num_q <= line_num_d;
            req_q      <= req_d;
            und_q      <= und_d;
        end
    end

    assign line_req_out = req_q;
    assign line_num_out = line_num_q;
    assign underrun_out = und_q;

`ifdef PPU_LINE_BUF_UNDERRUN_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) cnt_q <= '0;
        else if (und_d && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end

    assign underrun_cnt_out = cnt_q;
`else
    assign underrun_cnt_out = '0;
`endif
endmodule

// File: tb/tb_ppu_line_buf.sv
// tb_ppu_line_buf: scoreboard bench for the ping-pong scanline buffer with a line-level reference model.
module tb_ppu_line_buf;
    localparam int M_IDLE = 0, M_FILL = 1, M_READY = 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [9:0]  nes_x_in = '0, nes_y_in = '0, nes_y_next_in = '0;
    logic        pix_pulse_in = 1'b0;
    logic [5:0]  sys_palette_idx_out;
    logic        line_req_out;
    logic [7:0]  line_num_out;
    logic        wr_en_in = 1'b0;
    logic [7:0]  wr_x_in = '0;
    logic [5:0]  wr_idx_in = '0;
    logic        wr_done_in = 1'b0;
    logic        underrun_out;
    logic [15:0] underrun_cnt_out;

    ppu_line_buf dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .nes_x_in            (nes_x_in),
        .nes_y_in            (nes_y_in),
        .nes_y_next_in       (nes_y_next_in),
        .pix_pulse_in        (pix_pulse_in),
        .sys_palette_idx_out (sys_palette_idx_out),
        .line_req_out        (line_req_out),
        .line_num_out        (line_num_out),
        .wr_en_in            (wr_en_in),
        .wr_x_in             (wr_x_in),
        .wr_idx_in           (wr_idx_in),
        .wr_done_in          (wr_done_in),
        .underrun_out        (underrun_out),
        .underrun_cnt_out    (underrun_cnt_out)
    );

    always #10 clk_in = ~clk_in;

    typedef struct {
        int line;
        int und;
        int cnt;
    } req_t;

    req_t req_q[$];
    int   pix_q[$];
    int   n_chk = 0, n_fail = 0;
    bit   probe_v = 1'b0, rst_chk = 1'b0;

    // Model: the displayed line and the line being built, -1 marks unknown contents.
    int front[256], back[256];
    int ms, ml, mcnt;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (rst_chk) begin
            chk("rst_req", int'(line_req_out), 0);
            chk("rst_und", int'(underrun_out), 0);
            chk("rst_line", int'(line_num_out), 0);
            chk("rst_cnt", int'(underrun_cnt_out), 0);
        end
        if (line_req_out) begin
            if (req_q.size() == 0) chk("req_unexpected", 1, 0);
            else begin
                req_t e;
                e = req_q.pop_front();
                chk("req_line", int'(line_num_out), e.line);
                chk("req_und", int'(underrun_out), e.und);
                chk("und_cnt", int'(underrun_cnt_out), e.cnt);
            end
        end else if (underrun_out) chk("und_without_req", 1, 0);
        if (probe_v) begin
            if (pix_q.size() == 0) chk("pix_queue_empty", 1, 0);
            else chk("pix", int'(sys_palette_idx_out), pix_q.pop_front());
        end
    end

    task automatic model_reset();
        foreach (front[i]) begin
            front[i] = -1;
            back[i]  = -1;
        end
        ms = M_IDLE;
        ml = 0;
        mcnt = 0;
    endtask

    task automatic push_req(input int line, input int und);
        req_t r;
        r.line = line;
        r.und  = und;
`ifdef PPU_LINE_BUF_UNDERRUN_CNT_EN
        r.cnt  = mcnt;
`else
        r.cnt  = 0;
`endif
        req_q.push_back(r);
    endtask

    // One clock of stimulus; the model applies the same cycle's rules before the edge.
    task automatic step(input bit pix, input int x, input int y, input int yn,
                        input bit we, input int wx, input int wi, input bit dn, input bit probe);
        int  nms, tgt, tmp[256], e;
        bit  eol;
        pix_pulse_in  = pix;
        nes_x_in      = 10'(x);
        nes_y_in      = 10'(y);
        nes_y_next_in = 10'(yn);
        wr_en_in      = we;
        wr_x_in       = 8'(wx);
        wr_idx_in     = 6'(wi);
        wr_done_in    = dn;
        probe_v       = 1'b0;
        if (probe) begin
            e = (x < 256 && y < 240) ? front[x] : 0;
            if (e >= 0) begin
                pix_q.push_back(e);
                probe_v = 1'b1;
            end
        end
        eol = pix && x == 255 && yn != y;
        tgt = (yn == 239) ? 0 : yn + 1;
        if (we && ms == M_FILL) back[wx & 255] = wi & 63;
        nms = (ms == M_FILL && dn) ? M_READY : ms;
        if (eol && yn < 240) begin
            if (ms == M_IDLE) begin
                push_req(tgt, 0);
                nms = M_FILL;
                ml = tgt;
            end else if (ml == yn) begin
                if (ms == M_READY || dn) begin
                    tmp = front;
                    front = back;
                    back = tmp;
                    push_req(tgt, 0);
                end else begin
                    if (mcnt < 65535) mcnt++;
                    push_req(tgt, 1);
                end
                nms = M_FILL;
                ml = tgt;
            end
        end
        ms = nms;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_chk = 1'b1;
        @(posedge clk_in);
        #1;
        rst_chk = 1'b0;
        rst_in = 1'b0;
        model_reset();
    endtask

    task automatic eol_at(input int y, input int yn, input bit dn);
        step(1, 255, y, yn, 0, 0, 0, dn, 0);
    endtask

    task automatic wr(input int x, input int i);
        step(0, 0, 0, 0, 1, x, i, 0, 0);
    endtask

    task automatic rd(input int x, input int y);
        step(0, x, y, y, 0, 0, 0, 0, 1);
    endtask

    task automatic done();
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        int ycur, yn, rows, a;
        bit dbl, pdone;
        model_reset();
        do_reset();
        eol_at(9, 10, 0);
        for (int x = 0; x < 256; x++) wr(x, x & 63);
        done();
        eol_at(10, 11, 0);
        rd(37, 11);
        eol_at(11, 12, 0);
        rd(37, 12);
        rd(300, 5);
        rd(5, 250);
        for (int x = 0; x < 10; x++) wr(x, 7);
        do_reset();
        wr(3, 9);
        done();
        eol_at(237, 238, 0);
        for (int x = 0; x < 256; x++) wr(x, (x ^ 21) & 63);
        done();
        eol_at(238, 239, 0);
        rd(200, 239);
        for (int x = 0; x < 256; x++) wr(x, (x * 3) & 63);
        done();
        for (int y = 240; y < 245; y++) eol_at(y - 1, y, 0);
        rd(200, 239);
        eol_at(261, 0, 0);
        rd(100, 0);
        for (int x = 0; x < 64; x++) wr(x, int'($urandom_range(0, 63)));
        eol_at(0, 1, 1);
        rd(5, 1);
        for (int x = 0; x < 256; x++) wr(x, int'($urandom_range(0, 63)));
        done();
        for (int x = 0; x < 16; x++) wr(x, int'($urandom_range(0, 63)));
        eol_at(1, 2, 0);
        for (int x = 0; x < 16; x++) rd(x, 2);
        ycur = 2;
        for (int n = 0; n < 800; n++) begin
            yn    = (ycur == 261) ? 0 : ycur + 1;
            dbl   = ycur < 240 && $urandom_range(0, 1) == 1;
            pdone = $urandom_range(0, 99) < 65;
            rows  = dbl ? 2 : 1;
            for (int r = 0; r < rows; r++) begin
                for (int k = 0; k < 6; k++) begin
                    a = int'($urandom_range(0, 4));
                    if (a == 0) rd(int'($urandom_range(0, 299)), ycur);
                    else if (a <= 2) step(0, 0, ycur, ycur, 1, int'($urandom_range(0, 255)),
                                          int'($urandom_range(0, 63)), 0, 0);
                    else if (a == 3) step(1, int'($urandom_range(0, 254)), ycur, yn, 0, 0, 0,
                                          pdone && $urandom_range(0, 3) == 0, 1);
                    else step(0, 0, ycur, ycur, 0, 0, 0, pdone, 0);
                end
                eol_at(ycur, (r == rows - 1) ? yn : ycur, pdone && $urandom_range(0, 3) == 0);
            end
            ycur = yn;
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("req_drain", req_q.size(), 0);
        chk("pix_drain", pix_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
